boot_loader_dma: RTL and testbench

Descriptor-driven boot loader that sits in `top` between the boot ROM, the external instruction memory (`memory`), and the IM/DM arrays. After `system_enable` rises, it walks a descriptor list in ROM and copies blocks of words from memory into IM or DM at one word per cycle. It then raises `boot_done` so the core can leave hold. This block generalises the fixed single-image boot in three ways: parametrised widths, a multi-descriptor list with per-entry target select, and error and performance reporting.

---
 rtl/boot_loader_dma.sv | 174 +++++++++++++++++
 tb/tb_boot_loader_dma.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/boot_loader_dma.sv
// Descriptor-driven boot loader: walks a ROM descriptor list and copies
// word blocks from external memory into IM or DM at one word per cycle.
module boot_loader_dma #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ROM_AW = 8,
  parameter int unsigned MEM_AW = 16,
  parameter int unsigned DST_AW = 12,
  parameter int unsigned IM_AW  = 10,
  parameter int unsigned DM_AW  = 12,
  parameter int unsigned LEN_W  = 7,
  parameter int unsigned DESC_W = 2 + MEM_AW + DST_AW + LEN_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              system_enable,
  output logic              rom_enable,
  output logic              rom_read,
  output logic [ROM_AW-1:0] rom_address,
  input  logic [DESC_W-1:0] rom_out,
  output logic              MEM_en,
  output logic              MEM_read,
  output logic [MEM_AW-1:0] MEM_addr,
  input  logic [DATA_W-1:0] MEM_data,
  output logic              IM_enable,
  output logic              IM_write,
  output logic [IM_AW-1:0]  IM_address,
  output logic [DATA_W-1:0] IM_in,
  output logic              DM_enable,
  output logic              DM_write,
  output logic [DM_AW-1:0]  DM_address,
  output logic [DATA_W-1:0] DM_in,
  output logic              boot_done,
  output logic              boot_err,
  output logic [31:0]       boot_cycles,
  output logic [31:0]       words_copied
);

  typedef enum logic [2:0] {StIdle, StFetch, StDecode, StCopy, StDrain, StDone} state_e;

  localparam logic [ROM_AW-1:0] PtrMax = '1;
  localparam logic [LEN_W-1:0]  LenOne = 1;

  state_e              state_q, state_d;
  logic [ROM_AW-1:0]   ptr_q, ptr_d;
  logic [LEN_W-1:0]    k_q, k_d;
  logic                err_q, err_d;
  logic                last_q, tgt_q;
  logic [MEM_AW-1:0]   src_q;
  logic [DST_AW-1:0]   dst_q;
  logic [LEN_W-1:0]    len_q;
  logic [31:0]         cyc_q, words_q;

  // Descriptor fields as presented by the ROM during DECODE.
  logic                d_last, d_tgt;
  logic [MEM_AW-1:0]   d_src;
  logic [DST_AW-1:0]   d_dst;
  logic [LEN_W-1:0]    d_len;
  assign d_last = rom_out[DESC_W-1];
  assign d_tgt  = rom_out[DESC_W-2];
  assign d_src  = rom_out[LEN_W+DST_AW +: MEM_AW];
  assign d_dst  = rom_out[LEN_W +: DST_AW];
  assign d_len  = rom_out[LEN_W-1:0];

  // Write phase lags the read by one cycle: word k-1 lands while word k is requested.
  logic              wr, im_wr, dm_wr;
  logic [DST_AW-1:0] wr_off;
  assign wr     = (state_q == StCopy && k_q != '0) || state_q == StDrain;
  assign wr_off = dst_q + DST_AW'(k_q) - DST_AW'(1);
  assign im_wr  = wr & ~tgt_q;
  assign dm_wr  = wr & tgt_q;

  // Next-state logic: descriptor walk, skip/error decisions, copy counter.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    k_d     = k_q;
    err_d   = err_q;
    unique case (state_q)
      StIdle: begin
        ptr_d = '0;
        if (system_enable) state_d = StFetch;
      end
      StFetch: state_d = StDecode;
      StDecode: begin
        k_d = '0;
        if (d_len == '0 || (!d_tgt && d_dst[DST_AW-1:IM_AW] != '0)) begin
          if (d_len != '0) err_d = 1'b1;
          if (d_last) begin
            state_d = StDone;
          end else if (ptr_q == PtrMax) begin
            err_d   = 1'b1;
            state_d = StDone;
          end else begin
            ptr_d   = ptr_q + 1'b1;
            state_d = StFetch;
          end
        end else begin
          state_d = StCopy;
        end
      end
      StCopy: begin
        k_d = k_q + 1'b1;
        if (k_q == len_q - LenOne) state_d = StDrain;
      end
      StDrain: begin
        if (last_q) begin
          state_d = StDone;
        end else if (ptr_q == PtrMax) begin
          err_d   = 1'b1;
          state_d = StDone;
        end else begin
          ptr_d   = ptr_q + 1'b1;
          state_d = StFetch;
        end
      end
      StDone: state_d = StDone;
      default: state_d = StIdle;
    endcase
  end

  // State, descriptor latch and performance counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      k_q     <= '0;
      err_q   <= 1'b0;
      last_q  <= 1'b0;
      tgt_q   <= 1'b0;
      src_q   <= '0;
      dst_q   <= '0;
      len_q   <= '0;
      cyc_q   <= '0;
      words_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      k_q     <= k_d;
      err_q   <= err_d;
      if (state_q == StDecode) begin
        last_q <= d_last;
        tgt_q  <= d_tgt;
        src_q  <= d_src;
        dst_q  <= d_dst;
        len_q  <= d_len;
      end
      if (state_q != StIdle && state_q != StDone && cyc_q != '1) cyc_q <= cyc_q + 1'b1;
      if (wr) words_q <= words_q + 1'b1;
    end
  end

  // Strobes decoded from state; addresses and data gated to zero when idle.
  always_comb begin
    rom_enable   = state_q == StFetch;
    rom_read     = rom_enable;
    rom_address  = rom_enable ? ptr_q : '0;
    MEM_en       = state_q == StCopy;
    MEM_read     = MEM_en;
    MEM_addr     = MEM_en ? src_q + MEM_AW'(k_q) : '0;
    IM_enable    = im_wr;
    IM_write     = im_wr;
    IM_address   = im_wr ? IM_AW'(wr_off) : '0;
    IM_in        = im_wr ? MEM_data : '0;
    DM_enable    = dm_wr;
    DM_write     = dm_wr;
    DM_address   = dm_wr ? DM_AW'(wr_off) : '0;
    DM_in        = dm_wr ? MEM_data : '0;
    boot_done    = state_q == StDone;
    boot_err     = err_q;
    boot_cycles  = cyc_q;
    words_copied = words_q;
  end

endmodule

// File: tb/tb_boot_loader_dma.sv
// Directed bench for boot_loader_dma with ROM, memory and IM/DM models.
module tb_boot_loader_dma;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        system_enable = 1'b0;
  logic        rom_enable, rom_read;
  logic [7:0]  rom_address;
  logic [36:0] rom_out;
  logic        MEM_en, MEM_read;
  logic [15:0] MEM_addr;
  logic [31:0] MEM_data;
  logic        IM_enable, IM_write;
  logic [9:0]  IM_address;
  logic [31:0] IM_in;
  logic        DM_enable, DM_write;
  logic [11:0] DM_address;
  logic [31:0] DM_in;
  logic        boot_done, boot_err;
  logic [31:0] boot_cycles, words_copied;

  int n_checks = 0;
  int n_fail   = 0;

  logic [36:0] rom [256];
  logic [31:0] im  [1024];
  logic [31:0] dm  [4096];
  int          im_wr_cnt, dm_wr_cnt, both_cnt;

  always #5 clk = ~clk;

  boot_loader_dma dut (
    .clk          (clk),
    .rst          (rst),
    .system_enable(system_enable),
    .rom_enable   (rom_enable),
    .rom_read     (rom_read),
    .rom_address  (rom_address),
    .rom_out      (rom_out),
    .MEM_en       (MEM_en),
    .MEM_read     (MEM_read),
    .MEM_addr     (MEM_addr),
    .MEM_data     (MEM_data),
    .IM_enable    (IM_enable),
    .IM_write     (IM_write),
    .IM_address   (IM_address),
    .IM_in        (IM_in),
    .DM_enable    (DM_enable),
    .DM_write     (DM_write),
    .DM_address   (DM_address),
    .DM_in        (DM_in),
    .boot_done    (boot_done),
    .boot_err     (boot_err),
    .boot_cycles  (boot_cycles),
    .words_copied (words_copied)
  );

  // Memory contents are a fixed function of address.
  function automatic logic [31:0] mw(input logic [15:0] a);
    return {~a, a};
  endfunction

  function automatic logic [36:0] desc(input bit last, input bit tgt, input logic [15:0] src,
                                       input logic [11:0] dst, input logic [6:0] len);
    return {last, tgt, src, dst, len};
  endfunction

  // One-cycle-latency ROM and memory, and IM/DM write capture.
  always @(posedge clk) begin
    rom_out  <= rom[rom_address];
    MEM_data <= mw(MEM_addr);
    if (IM_enable && IM_write) begin
      im[IM_address] <= IM_in;
      im_wr_cnt      <= im_wr_cnt + 1;
    end
    if (DM_enable && DM_write) begin
      dm[DM_address] <= DM_in;
      dm_wr_cnt      <= dm_wr_cnt + 1;
    end
    if (IM_enable && DM_enable) both_cnt <= both_cnt + 1;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_all();
    for (int i = 0; i < 256; i++) rom[i] = '0;
    for (int i = 0; i < 1024; i++) im[i] = '0;
    for (int i = 0; i < 4096; i++) dm[i] = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    im_wr_cnt = 0;
    dm_wr_cnt = 0;
    both_cnt  = 0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic start();
    system_enable = 1'b1;
    @(negedge clk);
    system_enable = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    for (int i = 0; i < budget && !boot_done; i++) @(negedge clk);
    check(tag, 64'(boot_done), 64'd1);
  endtask

  initial begin
    clear_all();
    do_reset();

    // Reset state and idle hold without a start request.
    check("rst_done", 64'(boot_done), 0);
    check("rst_err", 64'(boot_err), 0);
    check("rst_cycles", 64'(boot_cycles), 0);
    check("rst_words", 64'(words_copied), 0);
    check("rst_strobes", 64'({rom_enable, MEM_en, IM_enable, DM_enable}), 0);
    repeat (5) @(negedge clk);
    check("idle_hold", 64'({rom_enable, boot_cycles}), 0);

    // Single IM descriptor: FETCH + DECODE + 4 COPY + DRAIN = 7 cycles.
    rom[0] = desc(1, 0, 16'h0000, 12'h080, 7'd4);
    start();
    wait_done("t1_done", 50);
    for (int i = 0; i < 4; i++) check($sformatf("t1_im%0d", i), 64'(im[10'h80 + i]), 64'(mw(16'(i))));
    check("t1_cycles", 64'(boot_cycles), 7);
    check("t1_words", 64'(words_copied), 4);
    check("t1_err", 64'(boot_err), 0);
    start();
    repeat (5) @(negedge clk);
    check("t1_ignore_en", 64'({boot_cycles, words_copied}), {32'd7, 32'd4});

    // IM then DM descriptor.
    clear_all();
    rom[0] = desc(0, 0, 16'h0020, 12'h010, 7'd3);
    rom[1] = desc(1, 1, 16'h0010, 12'h000, 7'd2);
    do_reset();
    start();
    wait_done("t2_done", 50);
    check("t2_dm0", 64'(dm[0]), 64'(mw(16'h10)));
    check("t2_dm1", 64'(dm[1]), 64'(mw(16'h11)));
    check("t2_im2", 64'(im[10'h12]), 64'(mw(16'h22)));
    check("t2_wrcnt", 64'({im_wr_cnt[15:0], dm_wr_cnt[15:0], both_cnt[15:0]}), {16'd3, 16'd2, 16'd0});
    check("t2_words", 64'(words_copied), 5);
    check("t2_cycles", 64'(boot_cycles), 11);

    // len=0 skip (2 cycles) then one DM word.
    clear_all();
    rom[0] = desc(0, 1, 16'h0000, 12'h000, 7'd0);
    rom[1] = desc(1, 1, 16'h0005, 12'h007, 7'd1);
    do_reset();
    start();
    wait_done("t3_done", 50);
    check("t3_dm7", 64'(dm[7]), 64'(mw(16'h5)));
    check("t3_cycles", 64'(boot_cycles), 6);
    check("t3_wr", 64'({dm_wr_cnt, words_copied}), {32'd1, 32'd1});
    check("t3_err", 64'(boot_err), 0);

    // Out-of-range IM destination is skipped with an error, next descriptor still runs.
    clear_all();
    rom[0] = desc(0, 0, 16'h0000, 12'h400, 7'd2);
    rom[1] = desc(1, 0, 16'h0030, 12'h001, 7'd1);
    do_reset();
    start();
    wait_done("t4_done", 50);
    check("t4_err", 64'(boot_err), 1);
    check("t4_im1", 64'(im[1]), 64'(mw(16'h30)));
    check("t4_wr", 64'({im_wr_cnt, words_copied}), {32'd1, 32'd1});
    check("t4_cycles", 64'(boot_cycles), 6);

    // Source and destination wrap.
    clear_all();
    rom[0] = desc(1, 0, 16'hFFFF, 12'h3FE, 7'd4);
    do_reset();
    start();
    wait_done("t5_done", 50);
    check("t5_im3fe", 64'(im[10'h3FE]), 64'(mw(16'hFFFF)));
    check("t5_im3ff", 64'(im[10'h3FF]), 64'(mw(16'h0000)));
    check("t5_im000", 64'(im[10'h000]), 64'(mw(16'h0001)));
    check("t5_im001", 64'(im[10'h001]), 64'(mw(16'h0002)));
    check("t5_err", 64'(boot_err), 0);

    // Every entry is a non-last skip: pointer overflow at the final entry.
    clear_all();
    do_reset();
    start();
    wait_done("t6_done", 700);
    check("t6_err", 64'(boot_err), 1);
    check("t6_cycles", 64'(boot_cycles), 512);
    check("t6_words", 64'(words_copied), 0);

    // Reset in the middle of a copy, then restart.
    clear_all();
    rom[0] = desc(1, 0, 16'h0040, 12'h100, 7'd6);
    do_reset();
    start();
    for (int i = 0; i < 50 && !(MEM_en && MEM_addr == 16'h0042); i++) @(negedge clk);
    check("t7_reach_k2", 64'({MEM_en, MEM_addr}), {47'd0, 1'b1, 16'h0042});
    rst = 1'b0;
    #1;
    check("t7_strobes", 64'({rom_enable, MEM_en, MEM_read, IM_enable, IM_write, DM_enable}), 0);
    check("t7_counters", 64'({boot_cycles, words_copied}), 0);
    check("t7_addr", 64'({MEM_addr, IM_address, IM_in}), 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    start();
    wait_done("t7_done", 50);
    for (int i = 0; i < 6; i++) check($sformatf("t7_im%0d", i), 64'(im[10'h100 + i]), 64'(mw(16'h40 + 16'(i))));
    check("t7_words", 64'(words_copied), 6);
    check("t7_cycles", 64'(boot_cycles), 9);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
